// File: rtl/fan_tach_rpm_pkg.sv
// Shared widths, limits and FSM encoding for the fan tachometer RPM meter.
package fan_pkg;

  localparam int RPM_W = 14;
  localparam logic [RPM_W-1:0] RPM_MAX = 14'h3FFF;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    CALC = 2'd2
  } fan_state_t;

  function automatic logic [RPM_W-1:0] sat_rpm(input logic [31:0] v);
    return (v > 32'(RPM_MAX)) ? RPM_MAX : v[RPM_W-1:0];
  endfunction

endpackage

// File: rtl/fan_tach_rpm_debounce.sv
// Tach input conditioning: 2-flop synchroniser, stability filter and
// single-cycle rising-edge pulse on the filtered level.
module tach_debounce
  import fan_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic CLK,
  input  logic nRST2,
  input  logic i_tach,
  output logic o_rise
);

  localparam int STAB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("tach_debounce: DEB_CYCLES must be at least 1");
  end

  logic              r_sync1;
  logic              r_sync2;
  logic              r_level;
  logic              r_level_q;
  logic [STAB_W-1:0] r_stab;

  // r_stab counts how many consecutive samples have disagreed with r_level;
  // the level flips on the DEB_CYCLES-th disagreeing sample.
  always_ff @(posedge CLK or negedge nRST2) begin
    if (!nRST2) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_stab    <= '0;
    end else begin
      r_sync1   <= i_tach;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 == r_level) begin
        r_stab <= '0;
      end else if (r_stab == STAB_LAST) begin
        r_level <= r_sync2;
        r_stab  <= '0;
      end else begin
        r_stab <= r_stab + 1'b1;
      end
    end
  end

  assign o_rise = r_level & ~r_level_q;

endmodule

// File: rtl/fan_tach_rpm.sv
// Gated tach-edge counter producing FAN_RPM / PRV_FAN_RPM once per window.
// Optional stall detection is built when FAN_STALL_DET_EN is defined.
module fan_tach_rpm
  import fan_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int GATE_MS        = 250,
  parameter int PULSES_PER_REV = 2,
  parameter int DEB_CYCLES     = 16,
  parameter int STALL_WINDOWS  = 4
) (
  input  logic             CLK,
  input  logic             nRST2,
  input  logic             ENABLE,
  input  logic             TACH,
  output logic [RPM_W-1:0] FAN_RPM,
  output logic [RPM_W-1:0] PRV_FAN_RPM,
  output logic             RPM_VALID,
  output logic             STALL
);

  localparam int PRE_DIV   = CLK_HZ / 1000;
  localparam int PRE_W     = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int MS_W      = (GATE_MS > 1) ? $clog2(GATE_MS) : 1;
  localparam int RPM_SCALE = 60000 / (GATE_MS * PULSES_PER_REV);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(GATE_MS - 1);

  if ((CLK_HZ % 1000) != 0 || PRE_DIV < 1) begin : g_bad_clk
    $error("fan_tach_rpm: CLK_HZ must be a non-zero multiple of 1000");
  end
  if (GATE_MS < 1 || PULSES_PER_REV < 1) begin : g_bad_gate
    $error("fan_tach_rpm: GATE_MS and PULSES_PER_REV must be at least 1");
  end
  if ((60000 % (GATE_MS * PULSES_PER_REV)) != 0) begin : g_bad_scale
    $error("fan_tach_rpm: GATE_MS*PULSES_PER_REV must divide 60000 exactly");
  end
  if (STALL_WINDOWS < 1) begin : g_bad_stall
    $error("fan_tach_rpm: STALL_WINDOWS must be at least 1");
  end

  fan_state_t       r_state;
  logic [PRE_W-1:0] r_pre;
  logic [MS_W-1:0]  r_ms;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cnt_latched;
  logic [RPM_W-1:0] r_fan_rpm;
  logic [RPM_W-1:0] r_prv_fan_rpm;
  logic             r_rpm_valid;

  logic             w_edge;
  logic             w_running;
  logic             w_ms_tick;
  logic             w_term;
  logic [CNT_W:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_sat;
  logic [31:0]      w_rpm_full;

  tach_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .CLK   (CLK),
    .nRST2 (nRST2),
    .i_tach(TACH),
    .o_rise(w_edge)
  );

  assign w_running  = (r_state != IDLE);
  assign w_ms_tick  = w_running && (r_pre == PRE_LAST);
  assign w_term     = w_ms_tick && (r_ms == MS_LAST);
  assign w_cnt_sum  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_edge};
  assign w_cnt_sat  = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
  assign w_rpm_full = 32'(r_cnt_latched) * 32'(RPM_SCALE);

  // The prescaler and ms counter wrap on the terminal cycle, so the next
  // window starts counting in CALC and no tach edge falls between windows.
  always_ff @(posedge CLK or negedge nRST2) begin
    if (!nRST2) begin
      r_state       <= IDLE;
      r_pre         <= '0;
      r_ms          <= '0;
      r_cnt         <= '0;
      r_cnt_latched <= '0;
      r_fan_rpm     <= '0;
      r_prv_fan_rpm <= '0;
      r_rpm_valid   <= 1'b0;
    end else if (!ENABLE) begin
      r_state       <= IDLE;
      r_pre         <= '0;
      r_ms          <= '0;
      r_cnt         <= '0;
      r_cnt_latched <= '0;
      r_rpm_valid   <= 1'b0;
    end else begin
      r_rpm_valid <= 1'b0;
      if (w_running) begin
        r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
        if (w_ms_tick) begin
          r_ms <= (r_ms == MS_LAST) ? '0 : r_ms + 1'b1;
        end
        if (w_term) begin
          r_cnt_latched <= w_cnt_sat;
          r_cnt         <= '0;
        end else begin
          r_cnt <= w_cnt_sat;
        end
      end
      case (r_state)
        IDLE: r_state <= GATE;
        GATE: begin
          if (w_term) begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_prv_fan_rpm <= r_fan_rpm;
          r_fan_rpm     <= sat_rpm(w_rpm_full);
          r_rpm_valid   <= 1'b1;
          r_state       <= w_term ? CALC : GATE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign FAN_RPM     = r_fan_rpm;
  assign PRV_FAN_RPM = r_prv_fan_rpm;
  assign RPM_VALID   = r_rpm_valid;

`ifdef FAN_STALL_DET_EN
  localparam int STW = ($clog2(STALL_WINDOWS + 1) > 3) ? $clog2(STALL_WINDOWS + 1) : 3;
  localparam logic [STW-1:0] ST_TARGET = STW'(STALL_WINDOWS);

  logic [STW-1:0] r_stall_cnt;
  logic           r_stall;

  // Evaluated alongside the RPM update so STALL changes with RPM_VALID.
  always_ff @(posedge CLK or negedge nRST2) begin
    if (!nRST2) begin
      r_stall_cnt <= '0;
      r_stall     <= 1'b0;
    end else if (ENABLE && (r_state == CALC)) begin
      if (r_cnt_latched == '0) begin
        if (r_stall_cnt != ST_TARGET) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
        if (r_stall_cnt >= ST_TARGET - 1'b1) begin
          r_stall <= 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
        r_stall     <= 1'b0;
      end
    end
  end

  assign STALL = r_stall;
`else
  assign STALL = 1'b0;
`endif

endmodule
